// File: rtl/bus_idle_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : bus_idle_monitor
//  Purpose  : Tracks the shared-bus handshake with a bus-phase state machine
//             and produces the registered busIdle qualifier for the profiling
//             counters, plus transaction/error counts and a watchdog flag.
//  Revision : 1.0  initial release
// ============================================================================
module bus_idle_monitor #(
  parameter int NR_MASTERS     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NR_MASTERS-1:0] busRequests,
  input  logic [NR_MASTERS-1:0] busGrants,
  input  logic                  beginTransaction,
  input  logic                  endTransaction,
  input  logic                  busError,
  input  logic                  clearFlags,
  output logic                  busIdle,
  output logic                  transferActive,
  output logic                  timeoutFlag,
  output logic [31:0]           transactionCount,
  output logic [15:0]           errorCount
);

  // Last watchdog value before a still-open transfer is declared hung.
  localparam logic [15:0] c_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_GRANTED = 3'd2,
    S_XFER    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        busIdle_q;
  logic        xferActive_q;
  logic        timeoutFlag_q, timeoutFlag_d;
  logic [31:0] txnCount_q, txnCount_d;
  logic [15:0] errCount_q, errCount_d;
  logic [15:0] watchdog_q, watchdog_d;

  logic        any_req;
  logic        any_gnt;
  logic        txn_evt;
  logic        err_evt;
  logic        to_evt;
  logic [15:0] err_base;

  assign any_req = |busRequests;
  assign any_gnt = |busGrants;

  // Next-state, watchdog and counter-update decode.
  always_comb begin
    state_d    = state_q;
    watchdog_d = 16'd0;
    txn_evt    = 1'b0;
    err_evt    = 1'b0;
    to_evt     = 1'b0;

    unique case (state_q)
      S_XFER: begin
        // Error beats end; either beats the watchdog in the same cycle.
        if (busError) begin
          state_d = S_RECOVER;
          err_evt = 1'b1;
        end else if (endTransaction) begin
          state_d = S_RECOVER;
          txn_evt = 1'b1;
        end else if (watchdog_q == c_WD_LAST) begin
          state_d = S_RECOVER;
          err_evt = 1'b1;
          to_evt  = 1'b1;
        end else begin
          watchdog_d = watchdog_q + 16'd1;
        end
      end
      // IDLE, ARB, GRANTED and RECOVER share one set of exit rules: a
      // grant holds GRANTED, a bare request holds ARB, nothing falls to IDLE.
      S_IDLE, S_ARB, S_GRANTED, S_RECOVER: begin
        if (beginTransaction && endTransaction) begin
          state_d = S_RECOVER;
          txn_evt = 1'b1;
        end else if (beginTransaction) begin
          state_d = S_XFER;
        end else if (any_gnt) begin
          state_d = S_GRANTED;
        end else if (any_req) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    txnCount_d = txnCount_q + (txn_evt ? 32'd1 : 32'd0);

    // A clear in the same cycle as a new event still records that event.
    timeoutFlag_d = clearFlags ? 1'b0 : timeoutFlag_q;
    if (to_evt) begin
      timeoutFlag_d = 1'b1;
    end

    err_base   = clearFlags ? 16'd0 : errCount_q;
    errCount_d = err_base;
    if (err_evt && (err_base != 16'hFFFF)) begin
      errCount_d = err_base + 16'd1;
    end
  end

  // State, decoded outputs and counters; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busIdle_q     <= 1'b1;
      xferActive_q  <= 1'b0;
      timeoutFlag_q <= 1'b0;
      txnCount_q    <= 32'd0;
      errCount_q    <= 16'd0;
      watchdog_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      busIdle_q     <= (state_d == S_IDLE);
      xferActive_q  <= (state_d == S_XFER);
      timeoutFlag_q <= timeoutFlag_d;
      txnCount_q    <= txnCount_d;
      errCount_q    <= errCount_d;
      watchdog_q    <= watchdog_d;
    end
  end

  assign busIdle          = busIdle_q;
  assign transferActive   = xferActive_q;
  assign timeoutFlag      = timeoutFlag_q;
  assign transactionCount = txnCount_q;
  assign errorCount       = errCount_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_idle_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_idle_monitor
//  Purpose  : Self-checking bench for bus_idle_monitor (4 masters, 8-cycle
//             watchdog). Each row of stimulus carries the outputs expected
//             one clock later; those are queued and compared after the edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_idle_monitor;

  localparam int NM = 4;
  localparam int TO = 8;

  logic          clock;
  logic          reset;
  logic [NM-1:0] busRequests;
  logic [NM-1:0] busGrants;
  logic          beginTransaction;
  logic          endTransaction;
  logic          busError;
  logic          clearFlags;
  logic          busIdle;
  logic          transferActive;
  logic          timeoutFlag;
  logic [31:0]   transactionCount;
  logic [15:0]   errorCount;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_txn;
  logic [15:0] exp_err;

  // Expected {busIdle, transferActive, timeoutFlag} after each driven cycle.
  logic [2:0] exp_q[$];

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       b;
    logic       e;
    logic       er;
    logic       cl;
    logic       idle;
    logic       act;
    logic       to;
  } row_t;

  bus_idle_monitor #(
    .NR_MASTERS     (NM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .busRequests      (busRequests),
    .busGrants        (busGrants),
    .beginTransaction (beginTransaction),
    .endTransaction   (endTransaction),
    .busError         (busError),
    .clearFlags       (clearFlags),
    .busIdle          (busIdle),
    .transferActive   (transferActive),
    .timeoutFlag      (timeoutFlag),
    .transactionCount (transactionCount),
    .errorCount       (errorCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic row_t r(input logic [3:0] req, input logic [3:0] gnt,
                             input logic b, input logic e, input logic er,
                             input logic cl, input logic idle, input logic act,
                             input logic to);
    row_t x;
    x.req = req; x.gnt = gnt; x.b = b; x.e = e; x.er = er; x.cl = cl;
    x.idle = idle; x.act = act; x.to = to;
    return x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, advance a clock.
  task automatic apply(input row_t x);
    busRequests      = x.req;
    busGrants        = x.gnt;
    beginTransaction = x.b;
    endTransaction   = x.e;
    busError         = x.er;
    clearFlags       = x.cl;
    exp_q.push_back({x.idle, x.act, x.to});
    tick();
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [2:0] e;
    reset = 1'b1;
    busRequests = '0; busGrants = '0;
    beginTransaction = 1'b0; endTransaction = 1'b0;
    busError = 1'b0; clearFlags = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busIdle, transferActive, timeoutFlag} !== 3'b100)
      $display("FAIL reset_outputs: got idle/act/to=%b expected 100", {busIdle, transferActive, timeoutFlag});
    else n_pass++;
    n_checks++;
    if (transactionCount !== 32'd0 || errorCount !== 16'd0)
      $display("FAIL reset_counts: got txn=%0d err=%0d expected 0/0", transactionCount, errorCount);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL reset_idle row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    exp_txn = 32'd0;
    exp_err = 16'd0;
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL reset_idle_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
  endtask

  task automatic test_handshake();
    row_t rows[$];
    logic [2:0] e;
    rows.push_back(r(4'h1, 4'h0, 0, 0, 0, 0, 0, 0, 0)); // c0 request -> ARB
    rows.push_back(r(4'h1, 4'h0, 0, 0, 0, 0, 0, 0, 0)); // c1
    rows.push_back(r(4'h1, 4'h1, 0, 0, 0, 0, 0, 0, 0)); // c2 grant -> GRANTED
    rows.push_back(r(4'h1, 4'h1, 0, 0, 0, 0, 0, 0, 0)); // c3
    rows.push_back(r(4'h1, 4'h1, 1, 0, 0, 0, 0, 1, 0)); // c4 begin -> XFER
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0)); // c5
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0)); // c6
    rows.push_back(r(4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0)); // c7 end -> RECOVER
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0)); // c8 -> IDLE
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL handshake row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    exp_txn = 32'd1;
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL handshake_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
  endtask

  task automatic test_single_cycle();
    row_t rows[$];
    logic [2:0] e;
    rows.push_back(r(4'h2, 4'h2, 0, 0, 0, 0, 0, 0, 0)); // -> GRANTED
    rows.push_back(r(4'h2, 4'h2, 1, 1, 0, 0, 0, 0, 0)); // begin+end -> RECOVER
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0)); // -> IDLE
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL single_cycle row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    exp_txn = 32'd2;
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL single_cycle_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [2:0] e;
    // Open transfer with no end: eight XFER cycles, then watchdog fires.
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < TO - 1; i++) rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL timeout row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    exp_err = 16'd1;
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL timeout_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
    // Clear flags on the begin cycle, then end lands on the 8th XFER cycle.
    rows.delete();
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 1, 0, 1, 0));
    for (int i = 0; i < TO - 1; i++) rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    rows.push_back(r(4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0));
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL end_at_limit row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    exp_txn = 32'd3;
    exp_err = 16'd0;
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL end_at_limit_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
  endtask

  task automatic test_arb_drop();
    row_t rows[$];
    logic [2:0] e;
    for (int i = 0; i < 3; i++) rows.push_back(r(4'h4, 4'h0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL arb_drop row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL arb_drop_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
  endtask

  task automatic test_errors();
    row_t rows[$];
    logic [2:0] e;
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 0)); // begin
    rows.push_back(r(4'h0, 4'h0, 0, 1, 1, 0, 0, 0, 0)); // end+error: error wins
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 0)); // begin
    rows.push_back(r(4'h0, 4'h0, 0, 0, 1, 1, 0, 0, 0)); // error+clear -> err=1
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(r(4'h0, 4'h0, 0, 1, 1, 0, 1, 0, 0)); // stray end/error in IDLE
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL errors row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    exp_err = 16'd1;
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL errors_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
    // Clear coinciding with a watchdog timeout: the new event survives.
    rows.delete();
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < TO - 1; i++) rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 1));
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL clear_timeout row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL clear_timeout_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [2:0] e;
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 1)); // begin
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 1)); // begin in XFER ignored
    rows.push_back(r(4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 1)); // end -> RECOVER
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 1)); // begin during RECOVER
    rows.push_back(r(4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 1)); // end -> RECOVER
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL back_to_back row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    exp_txn = 32'd5;
    n_checks++;
    if (transactionCount !== exp_txn || errorCount !== exp_err)
      $display("FAIL back_to_back_counts: got txn=%0d err=%0d expected %0d/%0d", transactionCount, errorCount, exp_txn, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_xfer();
    row_t rows[$];
    logic [2:0] e;
    rows.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 1));
    rows.push_back(r(4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({busIdle, transferActive, timeoutFlag} !== e)
        $display("FAIL reset_mid row %0d: got idle/act/to=%b expected %b", i, {busIdle, transferActive, timeoutFlag}, e);
      else n_pass++;
    end
    // End pulse coincides with reset: reset wins, transfer not counted.
    reset = 1'b1;
    endTransaction = 1'b1;
    tick();
    reset = 1'b0;
    endTransaction = 1'b0;
    n_checks++;
    if ({busIdle, transferActive, timeoutFlag} !== 3'b100)
      $display("FAIL reset_mid_outputs: got idle/act/to=%b expected 100", {busIdle, transferActive, timeoutFlag});
    else n_pass++;
    n_checks++;
    if (transactionCount !== 32'd0 || errorCount !== 16'd0)
      $display("FAIL reset_mid_counts: got txn=%0d err=%0d expected 0/0", transactionCount, errorCount);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_single_cycle();
    test_timeout();
    test_arb_drop();
    test_errors();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
